// File: rtl/dest_reg_pipe_pkg.sv
// Shared MIPS definitions: register-file geometry, pipeline depth and the
// destination-source encoding used by the writeback-address selector.
package dest_reg_pipe_pkg;

  localparam int unsigned MIPS_REG_W       = 5;
  localparam int unsigned MIPS_NUM_DST_SRC = 4;
  localparam int unsigned MIPS_PIPE_DEPTH  = 3;

  typedef enum logic [1:0] {
    DST_ITYPE = 2'd0,
    DST_RTYPE = 2'd1,
    DST_SWI   = 2'd2
  } dst_sel_e;

endpackage

// File: rtl/dest_reg_pipe_mux.sv
// N-to-1 address selector; an out-of-range select falls back to DEFAULT_SEL.
module mux_nto1 #(
  parameter int unsigned NUM_IN      = 4,
  parameter int unsigned WIDTH       = 5,
  parameter int unsigned DEFAULT_SEL = 1
) (
  input  logic [NUM_IN*WIDTH-1:0]   i_data,
  input  logic [$clog2(NUM_IN)-1:0] i_sel,
  output logic [WIDTH-1:0]          o_data
);

  localparam int unsigned SEL_W = $clog2(NUM_IN);

  always_comb begin
    o_data = i_data[DEFAULT_SEL*WIDTH +: WIDTH];
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (i_sel == SEL_W'(i)) o_data = i_data[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/dest_reg_pipe.sv
// Destination-register tracking pipeline (EX/MEM/WB) with operand hazard
// detection against every in-flight valid destination.
module dest_reg_pipe
  import dest_reg_pipe_pkg::*;
#(
  parameter int unsigned WIDTH       = MIPS_REG_W,
  parameter int unsigned NUM_IN      = MIPS_NUM_DST_SRC,
  parameter int unsigned DEPTH       = MIPS_PIPE_DEPTH,
  parameter int unsigned DEFAULT_SEL = 32'(DST_RTYPE),
  localparam int unsigned SEL_W      = $clog2(NUM_IN),
  localparam int unsigned STG_W      = ($clog2(DEPTH) > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] cand_addr,
  input  logic [SEL_W-1:0]        select,
  input  logic                    in_valid,
  input  logic                    stall,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        rs_addr,
  input  logic [WIDTH-1:0]        rt_addr,
  output logic [DEPTH*WIDTH-1:0]  stage_addr,
  output logic [DEPTH-1:0]        stage_valid,
  output logic [WIDTH-1:0]        wb_addr,
  output logic                    wb_valid,
  output logic                    hazard_rs,
  output logic                    hazard_rt,
  output logic [STG_W-1:0]        hazard_rs_stage,
  output logic [STG_W-1:0]        hazard_rt_stage
);

  localparam int unsigned PREV = (DEPTH > 1) ? DEPTH - 2 : 0;

  logic [WIDTH-1:0] r_addr [0:DEPTH-1];
  logic [DEPTH-1:0] r_valid;
  logic [WIDTH-1:0] w_nxt_addr [0:DEPTH-1];
  logic [DEPTH-1:0] w_nxt_valid;
  logic [WIDTH-1:0] w_sel_addr;
  logic [DEPTH-1:0] w_hit_rs;
  logic [DEPTH-1:0] w_hit_rt;

  mux_nto1 #(
    .NUM_IN     (NUM_IN),
    .WIDTH      (WIDTH),
    .DEFAULT_SEL(DEFAULT_SEL)
  ) u_sel (
    .i_data(cand_addr),
    .i_sel (select),
    .o_data(w_sel_addr)
  );

  // Flush keeps the oldest shift alive so the instruction ahead of the
  // squashed ones still retires; younger stages keep addresses, lose valid.
  always_comb begin
    w_nxt_addr  = r_addr;
    w_nxt_valid = r_valid;
    if (flush) begin
      for (int unsigned k = 0; k + 1 < DEPTH; k++) w_nxt_valid[k] = 1'b0;
      if (DEPTH > 1) begin
        w_nxt_addr[DEPTH-1]  = r_addr[PREV];
        w_nxt_valid[DEPTH-1] = r_valid[PREV];
      end else begin
        w_nxt_valid[0] = 1'b0;
      end
    end else if (!stall) begin
      w_nxt_addr[0]  = w_sel_addr;
      w_nxt_valid[0] = in_valid && (w_sel_addr != '0);
      for (int unsigned k = 1; k < DEPTH; k++) begin
        w_nxt_addr[k]  = r_addr[k-1];
        w_nxt_valid[k] = r_valid[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < DEPTH; k++) r_addr[k] <= '0;
      r_valid <= '0;
    end else begin
      r_addr  <= w_nxt_addr;
      r_valid <= w_nxt_valid;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    assign stage_addr[k*WIDTH +: WIDTH] = r_addr[k];
    assign w_hit_rs[k] = r_valid[k] && (r_addr[k] == rs_addr) && (rs_addr != '0);
    assign w_hit_rt[k] = r_valid[k] && (r_addr[k] == rt_addr) && (rt_addr != '0);
  end

  assign stage_valid = r_valid;
  assign wb_addr     = r_addr[DEPTH-1];
  assign wb_valid    = r_valid[DEPTH-1];
  assign hazard_rs   = |w_hit_rs;
  assign hazard_rt   = |w_hit_rt;

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    hazard_rs_stage = '0;
    hazard_rt_stage = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_hit_rs[DEPTH-1-k]) hazard_rs_stage = STG_W'(DEPTH-1-k);
      if (w_hit_rt[DEPTH-1-k]) hazard_rt_stage = STG_W'(DEPTH-1-k);
    end
  end

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed bench for dest_reg_pipe (NUM_IN=3 so an out-of-range select exists).
module tb_dest_reg_pipe;

  logic        clk;
  logic        rst_n;
  logic [14:0] cand_addr;
  logic [1:0]  select;
  logic        in_valid;
  logic        stall;
  logic        flush;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [14:0] stage_addr;
  logic [2:0]  stage_valid;
  logic [4:0]  wb_addr;
  logic        wb_valid;
  logic        hazard_rs;
  logic        hazard_rt;
  logic [1:0]  hazard_rs_stage;
  logic [1:0]  hazard_rt_stage;

  dest_reg_pipe #(
    .WIDTH      (5),
    .NUM_IN     (3),
    .DEPTH      (3),
    .DEFAULT_SEL(1)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cand_addr      (cand_addr),
    .select         (select),
    .in_valid       (in_valid),
    .stall          (stall),
    .flush          (flush),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .stage_addr     (stage_addr),
    .stage_valid    (stage_valid),
    .wb_addr        (wb_addr),
    .wb_valid       (wb_valid),
    .hazard_rs      (hazard_rs),
    .hazard_rt      (hazard_rt),
    .hazard_rs_stage(hazard_rs_stage),
    .hazard_rt_stage(hazard_rt_stage)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n, stall, flush, in_valid;
    logic [1:0] sel;
    logic [4:0] c0, c1, c2, rs, rt;
    logic [2:0] ev;
    logic [4:0] e0, e1, e2;
    logic       ehrs;
    logic [1:0] ehrss;
    logic       ehrt;
    logic [1:0] ehrts;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   row = 0;

  function automatic vec_t mk(
    input logic r, s, f, iv, input logic [1:0] sel,
    input logic [4:0] c0, c1, c2, rs, rt,
    input logic [2:0] ev, input logic [4:0] e0, e1, e2,
    input logic hrs, input logic [1:0] hrss, input logic hrt, input logic [1:0] hrts);
    vec_t v;
    v.rst_n = r; v.stall = s; v.flush = f; v.in_valid = iv; v.sel = sel;
    v.c0 = c0; v.c1 = c1; v.c2 = c2; v.rs = rs; v.rt = rt;
    v.ev = ev; v.e0 = e0; v.e1 = e1; v.e2 = e2;
    v.ehrs = hrs; v.ehrss = hrss; v.ehrt = hrt; v.ehrts = hrts;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n     = v.rst_n;
    stall     = v.stall;
    flush     = v.flush;
    in_valid  = v.in_valid;
    select    = v.sel;
    cand_addr = {v.c2, v.c1, v.c0};
    rs_addr   = v.rs;
    rt_addr   = v.rt;
  endtask

  task automatic check(input vec_t v);
    chk("stage_valid", 32'(stage_valid), 32'(v.ev));
    chk("stage_addr", 32'(stage_addr), 32'({v.e2, v.e1, v.e0}));
    chk("wb_valid", 32'(wb_valid), 32'(v.ev[2]));
    chk("wb_addr", 32'(wb_addr), 32'(v.e2));
    chk("hazard_rs", 32'(hazard_rs), 32'(v.ehrs));
    chk("hazard_rs_stage", 32'(hazard_rs_stage), 32'(v.ehrss));
    chk("hazard_rt", 32'(hazard_rt), 32'(v.ehrt));
    chk("hazard_rt_stage", 32'(hazard_rt_stage), 32'(v.ehrts));
  endtask

  task automatic run(input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(v);
    row++;
  endtask

  initial begin
    //          rst stl fl iv sel  c0  c1  c2  rs  rt   ev      e0  e1  e2  hrs ss hrt ts
    // reset held two cycles with in_valid high
    vecs.push_back(mk(0, 0, 0, 1, 1,  0,  9,  0,  0,  0, 3'b000,  0,  0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1,  0,  9,  0,  0,  0, 3'b000,  0,  0,  0, 0, 0, 0, 0));
    // latency: 9 reaches wb after three edges, valid for one cycle
    vecs.push_back(mk(1, 0, 0, 1, 1,  0,  9,  0,  9,  0, 3'b001,  9,  0,  0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0,  0,  0,  9,  0, 3'b010,  0,  9,  0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0,  0,  0,  9,  9, 3'b100,  0,  0,  9, 1, 2, 1, 2));
    vecs.push_back(mk(1, 0, 0, 0, 1,  0,  0,  0,  9,  0, 3'b000,  0,  0,  0, 0, 0, 0, 0));
    // out-of-range select -> source 1; zero address never valid; select 0
    vecs.push_back(mk(1, 0, 0, 1, 3,  2,  4,  6,  0,  4, 3'b001,  4,  0,  0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 1, 2,  3,  5,  0,  0,  0, 3'b010,  0,  4,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0,  3,  5,  6,  0,  0, 3'b101,  3,  0,  4, 0, 0, 0, 0));
    // fill 7, 8, 9 then stall twice, then stall+flush together
    vecs.push_back(mk(1, 0, 0, 1, 0,  7,  0,  0,  0,  0, 3'b011,  7,  3,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0,  8,  0,  0,  0,  0, 3'b111,  8,  7,  3, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0,  9,  0,  0,  0,  0, 3'b111,  9,  8,  7, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 0, 1, 0, 20,  0,  0,  8,  7, 3'b111,  9,  8,  7, 1, 1, 1, 2));
    vecs.push_back(mk(1, 1, 0, 1, 0, 20,  0,  0,  9,  0, 3'b111,  9,  8,  7, 1, 0, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 0, 21,  0,  0,  8,  9, 3'b100,  9,  8,  8, 1, 2, 0, 0));
    // hazard: 12 in stages 0 and 2, youngest wins; rs=0 never hazards
    vecs.push_back(mk(1, 0, 0, 1, 0, 12,  0,  0, 12,  0, 3'b001, 12,  9,  8, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  0,  0,  0, 12,  0, 3'b010,  0, 12,  9, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 12,  0,  0, 12, 12, 3'b101, 12,  0, 12, 1, 0, 1, 0));
    vecs.push_back(mk(1, 1, 0, 0, 0,  0,  0,  0,  0, 12, 3'b101, 12,  0, 12, 0, 0, 1, 0));
    // mid-pipeline reset discards everything, no stale wb_valid afterwards
    vecs.push_back(mk(1, 0, 0, 1, 0, 13,  0,  0,  0,  0, 3'b011, 13, 12,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 1, 0, 14,  0,  0, 12,  0, 3'b111, 14, 13, 12, 1, 2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 15,  0,  0, 12,  0, 3'b000,  0,  0,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0,  0,  0,  0, 12,  0, 3'b000,  0,  0,  0, 0, 0, 0, 0));

    drive(vecs[0]);
    #1;
    foreach (vecs[i]) run(vecs[i]);

    // flush without stall: incoming instruction dropped, stage 1 retires
    run(mk(1, 0, 0, 1, 0,  5,  0,  0,  5,  0, 3'b001,  5,  0,  0, 1, 0, 0, 0));
    run(mk(1, 0, 0, 1, 0,  6,  0,  0,  5,  6, 3'b011,  6,  5,  0, 1, 1, 1, 0));
    run(mk(1, 0, 1, 1, 0,  7,  0,  0,  5,  6, 3'b100,  6,  5,  5, 1, 2, 0, 0));
    run(mk(1, 0, 0, 1, 0, 10,  0,  0,  5, 10, 3'b001, 10,  6,  5, 0, 0, 1, 0));
    run(mk(1, 0, 0, 0, 0,  0,  0,  0, 10,  0, 3'b010,  0, 10,  6, 1, 1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dest_reg_pipe.md
DEST_REG_PIPE -- requirements
Module: dest_reg_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 5: register-address width in bits.
REQ-002 SHALL have parameter NUM_IN, default 4, minimum 2: number of candidate destination sources.
REQ-003 SHALL have parameter DEPTH, default 3, minimum 1: pipeline stages tracked (EX/MEM/WB).
REQ-004 SHALL have parameter DEFAULT_SEL, default 1: source used when the select value is out of range.
REQ-005 SHALL have these ports:
  clk  input  1  sole clock, rising edge.
  rst_n  input  1  synchronous, active-low reset.
  cand_addr  input  NUM_IN*WIDTH  flattened candidates; source i occupies bits [i*WIDTH +: WIDTH].
  select  input  clog2(NUM_IN)  candidate index.
  in_valid  input  1  instruction entering that writes a register.
  stall  input  1  hold all stages.
  flush  input  1  kill younger stages.
  rs_addr, rt_addr  input  WIDTH each  decode-stage source operands.
  stage_addr  output  DEPTH*WIDTH  registered address per stage; stage 0 is youngest.
  stage_valid  output  DEPTH  valid bit per stage.
  wb_addr, wb_valid  output  WIDTH, 1  oldest stage (DEPTH-1).
  hazard_rs, hazard_rt  output  1 each  operand matches an in-flight destination.
  hazard_rs_stage, hazard_rt_stage  output  clog2(DEPTH) or 1 bit, whichever is larger  youngest matching stage.

Function
REQ-006 SHALL select cand_addr source "select" when select < NUM_IN, and source DEFAULT_SEL otherwise.
REQ-007 SHALL, on each clk edge with stall=0 and flush=0, load the selected address and in_valid into stage 0, and shift stage k into stage k+1.
REQ-008 SHALL give a selected address latency of exactly DEPTH cycles to wb_addr when no stall occurs.
REQ-009 SHALL, on stall=1 with flush=0, hold all stage_addr and stage_valid values unchanged.
REQ-010 SHALL, on flush=1, clear stage_valid[0..DEPTH-2] and retire the stage DEPTH-2 contents into DEPTH-1 as a normal shift. With DEPTH=1, flush SHALL clear stage 0.
REQ-011 SHALL give flush priority over stall when both are asserted. The incoming in_valid SHALL be dropped.
REQ-012 SHALL force stage_valid to 0 when the selected address equals 0. Register $zero is never tracked.
REQ-013 SHALL compute hazard_rs combinationally as the OR over stages of (stage_valid[k] AND stage_addr[k]==rs_addr AND rs_addr!=0). hazard_rt SHALL be computed the same way.
REQ-014 SHALL drive hazard_*_stage with the lowest matching stage index, and with 0 when there is no match.
REQ-015 SHALL retain stage_addr contents whenever valid is cleared. Only the valid bits are cleared.

Reset
REQ-016 SHALL, on rst_n=0 at a clk edge, clear all stage_valid and stage_addr to 0. wb_valid and the hazard outputs SHALL read 0 from the following cycle.
REQ-017 SHALL give reset priority over stall and flush. A reset mid-pipeline SHALL discard all in-flight entries.

Structure
REQ-018 SHALL place the WIDTH, NUM_IN and DEPTH defaults, and the DEFAULT_SEL encoding (0=I-type, 1=R-type, 2=swi), in the shared MIPS package.
REQ-019 SHALL implement the selection as a parametrised sub-module mux_nto1 (NUM_IN, WIDTH, DEFAULT_SEL), instantiated once.
REQ-020 SHALL use a single registered pipeline array. The hazard comparators SHALL be a generate loop over DEPTH.

Verification
REQ-021 Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> all stage_valid=0 and wb_valid=0.
REQ-022 Latency: select=1, candidate1=5'd9, in_valid=1 for one cycle, DEPTH=3 -> wb_addr=9 and wb_valid=1 exactly 3 cycles later, for 1 cycle.
REQ-023 Out-of-range/zero: NUM_IN=3, select=3, candidate1=5'd4 -> stage 0 holds 4. A selected address of 0 -> stage_valid[0]=0.
REQ-024 Stall/flush: entries 7, 8, 9 in flight, then stall=1 for 2 cycles -> contents frozen. Then stall=1 and flush=1 together -> stage_valid = 3'b100, and wb_addr = 8 (stage 1 retires).
REQ-025 Hazard: stage 0 = 12 and stage 2 = 12, both valid, rs_addr=12 -> hazard_rs=1 and hazard_rs_stage=0. rs_addr=0 -> hazard_rs=0.
REQ-026 Mid-operation reset: rst_n=0 for 1 cycle with 3 valid entries -> all valid bits 0 on the next cycle, and no stale wb_valid.
